// File: rtl/rvh_pmp_check_arbiter.sv
// rvh_pmp_check_arbiter
//   Shares one combinational PMP permission-check port among REQ_COUNT
//   requesters (ITLB, DTLB, PTW). Requesters are served round-robin. CSR
//   writes to pmpcfg/pmpaddr are only let through while no check is in flight.
//
//   Optional build macro: RVH_PMP_ARB_FAST_RESP_EN
//     When defined, the response is offered in the CHECK cycle, straight from
//     the PMP. If the requester takes it in that cycle, the arbiter returns to
//     IDLE immediately, so a check costs 2 cycles instead of 3.
//
//   Ports
//     clk, rst                       clock, synchronous active-high reset
//     req_vld_i / req_rdy_o          per-requester request handshake
//     req_paddr_i, req_access_type_i,
//     req_priv_lvl_i                 packed per-requester payload
//     resp_vld_o / resp_rdy_i        per-requester response handshake
//     resp_fail_o                    check result, valid with resp_vld_o
//     pmp_check_*_o, pmp_priv_lvl_o  drive the PMP check port
//     pmp_check_fail_i               PMP check result
//     csr_cfg_set_vld_i,
//     csr_addr_set_vld_i             CSR write requests
//     csr_set_rdy_o                  CSR write accepted this cycle
//     pmp_cfg_set_vld_o,
//     pmp_addr_set_vld_o             CSR writes forwarded to the PMP

// Per-requester handshake decode.
module rvh_pmp_check_arbiter_lane #(
  parameter int REQ_ID_WIDTH = 2,
  parameter int LANE         = 0
) (
  input  logic                    gnt_vld,
  input  logic [REQ_ID_WIDTH-1:0] gnt_id,
  input  logic                    resp_act,
  input  logic [REQ_ID_WIDTH-1:0] id_q,
  output logic                    req_rdy,
  output logic                    resp_vld
);
  localparam logic [REQ_ID_WIDTH-1:0] MY_ID = REQ_ID_WIDTH'(LANE);
  assign req_rdy  = gnt_vld  && (gnt_id == MY_ID);
  assign resp_vld = resp_act && (id_q   == MY_ID);
endmodule

module rvh_pmp_check_arbiter #(
  parameter int REQ_COUNT    = 3,
  parameter int PADDR_WIDTH  = 56,
  parameter int REQ_ID_WIDTH = (REQ_COUNT > 1 ? $clog2(REQ_COUNT) : 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQ_COUNT-1:0]             req_vld_i,
  output logic [REQ_COUNT-1:0]             req_rdy_o,
  input  logic [REQ_COUNT*PADDR_WIDTH-1:0] req_paddr_i,
  input  logic [REQ_COUNT*2-1:0]           req_access_type_i,
  input  logic [REQ_COUNT*2-1:0]           req_priv_lvl_i,
  output logic [REQ_COUNT-1:0]             resp_vld_o,
  input  logic [REQ_COUNT-1:0]             resp_rdy_i,
  output logic                             resp_fail_o,
  output logic                             pmp_check_vld_o,
  output logic [PADDR_WIDTH-1:0]           pmp_check_paddr_o,
  output logic [1:0]                       pmp_check_access_type_o,
  output logic [1:0]                       pmp_priv_lvl_o,
  input  logic                             pmp_check_fail_i,
  input  logic                             csr_cfg_set_vld_i,
  input  logic                             csr_addr_set_vld_i,
  output logic                             csr_set_rdy_o,
  output logic                             pmp_cfg_set_vld_o,
  output logic                             pmp_addr_set_vld_o
);

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_e;

  typedef struct packed {
    logic [PADDR_WIDTH-1:0]  paddr;
    logic [1:0]              access_type;
    logic [1:0]              priv;
    logic [REQ_ID_WIDTH-1:0] id;
  } req_t;

  state_e                  state;
  logic [REQ_ID_WIDTH-1:0] rr_ptr;
  req_t                    req_q;
  logic                    fail_q;

  // Unpack the per-requester payload.
  req_t req_in [REQ_COUNT];
  for (genvar k = 0; k < REQ_COUNT; k++) begin : g_unpack
    assign req_in[k].paddr       = req_paddr_i[k*PADDR_WIDTH +: PADDR_WIDTH];
    assign req_in[k].access_type = req_access_type_i[k*2 +: 2];
    assign req_in[k].priv        = req_priv_lvl_i[k*2 +: 2];
    assign req_in[k].id          = REQ_ID_WIDTH'(k);
  end

  // Round-robin pick: the first valid requester at or after rr_ptr.
  logic [REQ_ID_WIDTH-1:0] gnt_id;
  logic                    gnt_found;
  always_comb begin
    gnt_id    = '0;
    gnt_found = 1'b0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % REQ_COUNT;
      if (!gnt_found && req_vld_i[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = REQ_ID_WIDTH'(idx);
      end
    end
  end

  logic in_idle, in_check, in_resp, csr_any, gnt_vld, resp_act, resp_fire;
  assign in_idle  = !rst && (state == IDLE);
  assign in_check = !rst && (state == CHECK);
  assign in_resp  = !rst && (state == RESP);
  assign csr_any  = csr_cfg_set_vld_i || csr_addr_set_vld_i;
  // CSR writes win over a grant in the same IDLE cycle.
  assign gnt_vld  = in_idle && !csr_any && gnt_found;

`ifdef RVH_PMP_ARB_FAST_RESP_EN
  assign resp_act    = in_check || in_resp;
  assign resp_fail_o = in_check ? pmp_check_fail_i : (in_resp && fail_q);
`else
  assign resp_act    = in_resp;
  assign resp_fail_o = in_resp && fail_q;
`endif

  for (genvar k = 0; k < REQ_COUNT; k++) begin : g_lane
    rvh_pmp_check_arbiter_lane #(
      .REQ_ID_WIDTH (REQ_ID_WIDTH),
      .LANE         (k)
    ) u_lane (
      .gnt_vld  (gnt_vld),
      .gnt_id   (gnt_id),
      .resp_act (resp_act),
      .id_q     (req_q.id),
      .req_rdy  (req_rdy_o[k]),
      .resp_vld (resp_vld_o[k])
    );
  end

  // Only the owning requester's ready can complete the response.
  assign resp_fire = |(resp_vld_o & resp_rdy_i);

  assign csr_set_rdy_o      = in_idle;
  assign pmp_cfg_set_vld_o  = in_idle && csr_cfg_set_vld_i;
  assign pmp_addr_set_vld_o = in_idle && csr_addr_set_vld_i;

  assign pmp_check_vld_o         = in_check;
  assign pmp_check_paddr_o       = rst ? '0 : req_q.paddr;
  assign pmp_check_access_type_o = rst ? '0 : req_q.access_type;
  assign pmp_priv_lvl_o          = rst ? '0 : req_q.priv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      req_q  <= '0;
      fail_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          req_q  <= req_in[gnt_id];
          rr_ptr <= REQ_ID_WIDTH'((int'(gnt_id) + 1) % REQ_COUNT);
          state  <= CHECK;
        end
        CHECK: begin
          fail_q <= pmp_check_fail_i;
`ifdef RVH_PMP_ARB_FAST_RESP_EN
          state  <= resp_fire ? IDLE : RESP;
`else
          state  <= RESP;
`endif
        end
        RESP: if (resp_fire) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvh_pmp_check_arbiter.sv
// Directed, table-driven bench for rvh_pmp_check_arbiter (default build).
// Each table row is one clock cycle: inputs applied after the falling edge,
// outputs compared just afterwards, before the next rising edge.
module tb_rvh_pmp_check_arbiter;
  localparam int N  = 3;
  localparam int PW = 56;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_vld_i, req_rdy_o, resp_vld_o, resp_rdy_i;
  logic [N*PW-1:0]  req_paddr_i;
  logic [N*2-1:0]   req_access_type_i, req_priv_lvl_i;
  logic             resp_fail_o, pmp_check_vld_o, pmp_check_fail_i;
  logic [PW-1:0]    pmp_check_paddr_o;
  logic [1:0]       pmp_check_access_type_o, pmp_priv_lvl_o;
  logic             csr_cfg_set_vld_i, csr_addr_set_vld_i, csr_set_rdy_o;
  logic             pmp_cfg_set_vld_o, pmp_addr_set_vld_o;

  always #5 clk = ~clk;

  rvh_pmp_check_arbiter #(.REQ_COUNT(N), .PADDR_WIDTH(PW)) dut (
    .clk(clk), .rst(rst),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o),
    .req_paddr_i(req_paddr_i), .req_access_type_i(req_access_type_i),
    .req_priv_lvl_i(req_priv_lvl_i),
    .resp_vld_o(resp_vld_o), .resp_rdy_i(resp_rdy_i), .resp_fail_o(resp_fail_o),
    .pmp_check_vld_o(pmp_check_vld_o), .pmp_check_paddr_o(pmp_check_paddr_o),
    .pmp_check_access_type_o(pmp_check_access_type_o),
    .pmp_priv_lvl_o(pmp_priv_lvl_o), .pmp_check_fail_i(pmp_check_fail_i),
    .csr_cfg_set_vld_i(csr_cfg_set_vld_i), .csr_addr_set_vld_i(csr_addr_set_vld_i),
    .csr_set_rdy_o(csr_set_rdy_o),
    .pmp_cfg_set_vld_o(pmp_cfg_set_vld_o), .pmp_addr_set_vld_o(pmp_addr_set_vld_o)
  );

  // Fixed per-requester payload.
  logic [PW-1:0] paddr [N];
  logic [1:0]    atype [N];
  logic [1:0]    priv  [N];

  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] rv, rr;
    logic       cfg, addr, fin;
    logic [2:0] e_rdy;
    logic       e_chk;
    int         e_id;
    logic [2:0] e_rvld;
    logic       e_fail, e_csr, e_cfg, e_addr;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string name, logic r, logic [2:0] rv, logic [2:0] rr,
                              logic cfg, logic addr, logic fin,
                              logic [2:0] e_rdy, logic e_chk, int e_id,
                              logic [2:0] e_rvld, logic e_fail,
                              logic e_csr, logic e_cfg, logic e_addr);
    vec_t v;
    v.name = name; v.rst = r; v.rv = rv; v.rr = rr; v.cfg = cfg; v.addr = addr;
    v.fin = fin; v.e_rdy = e_rdy; v.e_chk = e_chk; v.e_id = e_id;
    v.e_rvld = e_rvld; v.e_fail = e_fail; v.e_csr = e_csr; v.e_cfg = e_cfg;
    v.e_addr = e_addr;
    return v;
  endfunction

  task automatic cmp(string name, int row, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    int lat;
    bit found;
    for (int k = 0; k < N; k++) begin
      paddr[k] = 56'h8000_0000 + PW'(k) * 56'h1000;
      atype[k] = 2'(k);
      priv[k]  = (k == 2) ? 2'd3 : ((k == 0) ? 2'd1 : 2'd0);
      req_paddr_i[k*PW +: PW]     = paddr[k];
      req_access_type_i[k*2 +: 2] = atype[k];
      req_priv_lvl_i[k*2 +: 2]    = priv[k];
    end
    rst = 1; req_vld_i = '0; resp_rdy_i = '0; pmp_check_fail_i = 0;
    csr_cfg_set_vld_i = 0; csr_addr_set_vld_i = 0;

    //            name      rst rv      rr      cfg adr fin  e_rdy  chk id e_rvld fail csr cfg adr
    vq.push_back(mk("reset",   1, 3'b111, 3'b111, 1, 1, 1, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0));
    // single request to requester 1
    vq.push_back(mk("single",  0, 3'b010, 3'b000, 0, 0, 0, 3'b010, 0, 0, 3'b000, 0, 1, 0, 0));
    vq.push_back(mk("single",  0, 3'b000, 3'b000, 0, 0, 1, 3'b000, 1, 1, 3'b000, 0, 0, 0, 0));
    vq.push_back(mk("single",  0, 3'b000, 3'b010, 0, 0, 0, 3'b000, 0, 0, 3'b010, 1, 0, 0, 0));
    vq.push_back(mk("single",  0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 3'b000, 0, 1, 0, 0));
    // round robin from a fresh reset
    vq.push_back(mk("rr_rst",  1, 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0));
    vq.push_back(mk("rr",      0, 3'b111, 3'b111, 0, 0, 0, 3'b001, 0, 0, 3'b000, 0, 1, 0, 0));
    vq.push_back(mk("rr",      0, 3'b111, 3'b111, 0, 0, 0, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0));
    vq.push_back(mk("rr",      0, 3'b111, 3'b111, 0, 0, 0, 3'b000, 0, 0, 3'b001, 0, 0, 0, 0));
    vq.push_back(mk("rr",      0, 3'b111, 3'b111, 0, 0, 0, 3'b010, 0, 0, 3'b000, 0, 1, 0, 0));
    vq.push_back(mk("rr",      0, 3'b111, 3'b111, 0, 0, 0, 3'b000, 1, 1, 3'b000, 0, 0, 0, 0));
    vq.push_back(mk("rr",      0, 3'b111, 3'b111, 0, 0, 0, 3'b000, 0, 0, 3'b010, 0, 0, 0, 0));
    vq.push_back(mk("rr",      0, 3'b111, 3'b111, 0, 0, 0, 3'b100, 0, 0, 3'b000, 0, 1, 0, 0));
    vq.push_back(mk("rr",      0, 3'b111, 3'b111, 0, 0, 1, 3'b000, 1, 2, 3'b000, 0, 0, 0, 0));
    vq.push_back(mk("rr",      0, 3'b111, 3'b111, 0, 0, 0, 3'b000, 0, 0, 3'b100, 1, 0, 0, 0));
    vq.push_back(mk("rr_wrap", 0, 3'b111, 3'b111, 0, 0, 0, 3'b001, 0, 0, 3'b000, 0, 1, 0, 0));
    vq.push_back(mk("rr",      0, 3'b000, 3'b111, 0, 0, 0, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0));
    vq.push_back(mk("rr",      0, 3'b000, 3'b001, 0, 0, 0, 3'b000, 0, 0, 3'b001, 0, 0, 0, 0));
    // CSR priority, then grant next cycle (wraps past rr_ptr=1 to requester 0)
    vq.push_back(mk("csr_pri", 0, 3'b001, 3'b000, 0, 1, 0, 3'b000, 0, 0, 3'b000, 0, 1, 0, 1));
    vq.push_back(mk("csr_pri", 0, 3'b001, 3'b000, 0, 0, 0, 3'b001, 0, 0, 3'b000, 0, 1, 0, 0));
    // CSR hold through CHECK and 4 stalled RESP cycles; foreign ready ignored
    vq.push_back(mk("csr_hld", 0, 3'b000, 3'b000, 1, 0, 0, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0));
    vq.push_back(mk("csr_hld", 0, 3'b000, 3'b000, 1, 0, 0, 3'b000, 0, 0, 3'b001, 0, 0, 0, 0));
    vq.push_back(mk("csr_hld", 0, 3'b000, 3'b110, 1, 0, 0, 3'b000, 0, 0, 3'b001, 0, 0, 0, 0));
    vq.push_back(mk("csr_hld", 0, 3'b000, 3'b000, 1, 0, 0, 3'b000, 0, 0, 3'b001, 0, 0, 0, 0));
    vq.push_back(mk("csr_hld", 0, 3'b000, 3'b000, 1, 0, 0, 3'b000, 0, 0, 3'b001, 0, 0, 0, 0));
    vq.push_back(mk("csr_hld", 0, 3'b000, 3'b001, 1, 0, 0, 3'b000, 0, 0, 3'b001, 0, 0, 0, 0));
    vq.push_back(mk("csr_acc", 0, 3'b000, 3'b000, 1, 0, 0, 3'b000, 0, 0, 3'b000, 0, 1, 1, 0));
    vq.push_back(mk("csr_both",0, 3'b111, 3'b000, 1, 1, 0, 3'b000, 0, 0, 3'b000, 0, 1, 1, 1));
    // backpressure: fail captured once, PMP toggling ignored, no new grant
    vq.push_back(mk("bp",      0, 3'b100, 3'b000, 0, 0, 0, 3'b100, 0, 0, 3'b000, 0, 1, 0, 0));
    vq.push_back(mk("bp",      0, 3'b011, 3'b000, 0, 0, 1, 3'b000, 1, 2, 3'b000, 0, 0, 0, 0));
    vq.push_back(mk("bp",      0, 3'b011, 3'b000, 0, 0, 0, 3'b000, 0, 0, 3'b100, 1, 0, 0, 0));
    vq.push_back(mk("bp",      0, 3'b011, 3'b000, 0, 0, 1, 3'b000, 0, 0, 3'b100, 1, 0, 0, 0));
    vq.push_back(mk("bp",      0, 3'b011, 3'b000, 0, 0, 0, 3'b000, 0, 0, 3'b100, 1, 0, 0, 0));
    vq.push_back(mk("bp",      0, 3'b011, 3'b000, 0, 0, 1, 3'b000, 0, 0, 3'b100, 1, 0, 0, 0));
    vq.push_back(mk("bp",      0, 3'b011, 3'b000, 0, 0, 0, 3'b000, 0, 0, 3'b100, 1, 0, 0, 0));
    vq.push_back(mk("bp",      0, 3'b011, 3'b100, 0, 0, 0, 3'b000, 0, 0, 3'b100, 1, 0, 0, 0));
    vq.push_back(mk("bp_next", 0, 3'b011, 3'b000, 0, 0, 0, 3'b001, 0, 0, 3'b000, 0, 1, 0, 0));
    // reset mid-RESP: response dropped, rr_ptr back to 0 (would be 1 otherwise)
    vq.push_back(mk("rst_mid", 0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0));
    vq.push_back(mk("rst_mid", 0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 3'b001, 0, 0, 0, 0));
    vq.push_back(mk("rst_mid", 1, 3'b111, 3'b000, 0, 0, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0));
    vq.push_back(mk("rst_aft", 0, 3'b111, 3'b000, 0, 0, 0, 3'b001, 0, 0, 3'b000, 0, 1, 0, 0));
    vq.push_back(mk("rst_aft", 0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0));
    vq.push_back(mk("rst_aft", 0, 3'b000, 3'b001, 0, 0, 0, 3'b000, 0, 0, 3'b001, 0, 0, 0, 0));

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; req_vld_i = vq[i].rv; resp_rdy_i = vq[i].rr;
      csr_cfg_set_vld_i = vq[i].cfg; csr_addr_set_vld_i = vq[i].addr;
      pmp_check_fail_i = vq[i].fin;
      #1;
      cmp({vq[i].name, ".req_rdy"},   i, 64'(req_rdy_o),          64'(vq[i].e_rdy));
      cmp({vq[i].name, ".chk_vld"},   i, 64'(pmp_check_vld_o),    64'(vq[i].e_chk));
      cmp({vq[i].name, ".resp_vld"},  i, 64'(resp_vld_o),         64'(vq[i].e_rvld));
      cmp({vq[i].name, ".resp_fail"}, i, 64'(resp_fail_o),        64'(vq[i].e_fail));
      cmp({vq[i].name, ".csr_rdy"},   i, 64'(csr_set_rdy_o),      64'(vq[i].e_csr));
      cmp({vq[i].name, ".cfg_set"},   i, 64'(pmp_cfg_set_vld_o),  64'(vq[i].e_cfg));
      cmp({vq[i].name, ".addr_set"},  i, 64'(pmp_addr_set_vld_o), 64'(vq[i].e_addr));
      if (vq[i].e_chk) begin
        cmp({vq[i].name, ".chk_paddr"}, i, 64'(pmp_check_paddr_o),       64'(paddr[vq[i].e_id]));
        cmp({vq[i].name, ".chk_type"},  i, 64'(pmp_check_access_type_o), 64'(atype[vq[i].e_id]));
        cmp({vq[i].name, ".chk_priv"},  i, 64'(pmp_priv_lvl_o),          64'(priv[vq[i].e_id]));
      end
      if (vq[i].rst)
        cmp({vq[i].name, ".paddr_rst"}, i, 64'(pmp_check_paddr_o), 64'(0));
    end

    // Latency: accept at T, response must appear at T+2 (bounded wait).
    @(negedge clk);
    rst = 0; req_vld_i = 3'b100; resp_rdy_i = 3'b100; pmp_check_fail_i = 0;
    csr_cfg_set_vld_i = 0; csr_addr_set_vld_i = 0;
    #1;
    cmp("lat.accept", -1, 64'(req_rdy_o), 64'(3'b100));
    found = 0; lat = 0;
    for (int c = 1; c <= 8 && !found; c++) begin
      @(negedge clk);
      req_vld_i = '0;
      #1;
      if (resp_vld_o[2]) begin found = 1; lat = c; end
    end
    cmp("lat.found", -1, 64'(found), 64'(1));
    cmp("lat.cycles", -1, 64'(lat), 64'(2));
    @(negedge clk);
    resp_rdy_i = '0;
    #1;
    cmp("lat.idle_resp", -1, 64'(resp_vld_o), 64'(0));
    cmp("lat.idle_csr", -1, 64'(csr_set_rdy_o), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/rvh_pmp_check_arbiter.md
Name: rvh_pmp_check_arbiter

Overview:
- Shares the single PMP permission-check port between REQ_COUNT requesters (ITLB, DTLB, PTW) with round-robin arbitration and per-requester valid/ready request and response handshakes.
- Sequences CSR writes to pmpcfg/pmpaddr so that a write never lands while a check is in flight.
- Sits between the MMU requesters and the PMP instance, which is built with its input register disabled (check is combinational).

Parameters:
REQ_COUNT, 3, number of requesters (>=1)
PADDR_WIDTH, 56, physical address width
REQ_ID_WIDTH, (REQ_COUNT>1 ? $clog2(REQ_COUNT) : 1), width of the granted-requester index

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous active-high
req_vld_i  input  REQ_COUNT  request valid per requester
req_rdy_o  output  REQ_COUNT  request accepted (one-hot or zero)
req_paddr_i  input  REQ_COUNT*PADDR_WIDTH  packed paddr; requester k at [k*PADDR_WIDTH +: PADDR_WIDTH]
req_access_type_i  input  REQ_COUNT*2  packed access type
req_priv_lvl_i  input  REQ_COUNT*2  packed effective privilege
resp_vld_o  output  REQ_COUNT  response valid (one-hot or zero)
resp_rdy_i  input  REQ_COUNT  response accepted
resp_fail_o  output  1  check failed (valid with resp_vld_o)
pmp_check_vld_o  output  1  to PMP permission_check_vld_i
pmp_check_paddr_o  output  PADDR_WIDTH  to PMP permission_check_paddr_i
pmp_check_access_type_o  output  2  to PMP permission_check_access_type_i
pmp_priv_lvl_o  output  2  to PMP priv_lvl_i
pmp_check_fail_i  input  1  from PMP permission_check_fail_o
csr_cfg_set_vld_i  input  1  CSR unit requests pmpcfg write
csr_addr_set_vld_i  input  1  CSR unit requests pmpaddr write
csr_set_rdy_o  output  1  CSR write accepted this cycle
pmp_cfg_set_vld_o  output  1  to PMP cfg_set_vld_i
pmp_addr_set_vld_o  output  1  to PMP addr_set_vld_i

Behaviour:
- FSM states: IDLE, CHECK, RESP. Reset: state=IDLE, rr_ptr=0, captured payload regs=0.
- Output values while rst is high: all outputs 0.
- IDLE:
  - csr_set_rdy_o=1.
  - pmp_cfg_set_vld_o = csr_cfg_set_vld_i; pmp_addr_set_vld_o = csr_addr_set_vld_i. Both may assert in the same cycle.
  - If any CSR write is valid, no grant is made that cycle and the state stays IDLE (CSR writes have priority).
  - Else if |req_vld_i: grant g = first valid requester at or after rr_ptr (wrapping modulo REQ_COUNT).
  - On grant: req_rdy_o[g]=1; capture paddr/type/priv/g; rr_ptr <= (g+1) mod REQ_COUNT; go to CHECK.
- CHECK:
  - pmp_check_vld_o=1, driven from the captured regs; pmp_priv_lvl_o = captured priv.
  - fail_q <= pmp_check_fail_i; go to RESP.
- RESP:
  - resp_vld_o[id]=1, resp_fail_o=fail_q.
  - Hold until resp_rdy_i[id]=1, then go to IDLE. Other requesters' resp_rdy_i are ignored.
- Outside IDLE:
  - csr_set_rdy_o=0 and pmp_*_set_vld_o=0; the CSR unit must hold its write.
  - req_rdy_o=0.
  - pmp_check_vld_o=0 except in CHECK.
- Latency: request accepted at cycle T, response valid at T+2. Peak throughput is one check per 3 cycles.
- Requester may drop req_vld_i after acceptance; the payload is already captured. Requester drops before grant: no effect.
- rst asserted in CHECK/RESP: in-flight request is discarded, no response is issued, state goes to IDLE, rr_ptr=0.
- REQ_COUNT=1: rr_ptr is constant 0.
- pmp_priv_lvl_o outside CHECK: captured value. The PMP output is ignored outside CHECK.

Optional Feature:
Macro RVH_PMP_ARB_FAST_RESP_EN.
- Defined:
  - In CHECK, resp_vld_o[id]=1 and resp_fail_o=pmp_check_fail_i combinationally.
  - If resp_rdy_i[id]=1 in CHECK, go directly to IDLE (latency T+1, throughput one per 2 cycles).
  - Else go to RESP with fail_q captured; behaviour from there matches the macro-undefined case.
- Undefined: behaviour as in Behaviour section; resp_vld_o is never asserted in CHECK.

Test Plan:
- Single request:
  - Stimulus: reset; req_vld_i=3'b010, paddr1=56'h8000_1000, type=2'b01, priv=0; pmp_check_fail_i=1 in CHECK; resp_rdy_i=3'b010.
  - Response: req_rdy_o=3'b010 at T; pmp_check_vld_o=1 with paddr 56'h8000_1000 at T+1; resp_vld_o=3'b010, resp_fail_o=1 at T+2; IDLE at T+3.
- Round-robin:
  - Stimulus: req_vld_i=3'b111 held; every response accepted immediately.
  - Response: grant order 0,1,2,0; grants 3 cycles apart.
- CSR priority:
  - Stimulus: csr_addr_set_vld_i=1 and req_vld_i=3'b001 in the same IDLE cycle.
  - Response: pmp_addr_set_vld_o=1, req_rdy_o=0 that cycle; grant to 0 next cycle.
- CSR hold:
  - Stimulus: csr_cfg_set_vld_i raised in CHECK; resp_rdy_i low for 4 cycles.
  - Response: csr_set_rdy_o=0 and pmp_cfg_set_vld_o=0 throughout; write accepted in the first IDLE cycle.
- Backpressure:
  - Stimulus: resp_rdy_i=0 for 5 cycles in RESP while pmp_check_fail_i toggles.
  - Response: resp_fail_o stable; no new grant.
- Reset mid-RESP:
  - Stimulus: rst=1 for 1 cycle during RESP.
  - Response: resp_vld_o=0 next cycle; state IDLE; next grant starts at requester 0.
  - With RVH_PMP_ARB_FAST_RESP_EN and resp_rdy_i=1: resp_vld_o at T+1 and the next grant possible at T+2.
